instruction_fetch: RTL

Fetch-side responder for the 8-bit MIPS datapath. It accepts a byte address from the program counter and reads four consecutive bytes from the synchronous byte-wide instruction memory. It assembles them big-endian into a 32-bit instruction and presents that instruction to the decoder with a one-cycle valid pulse. It also back-pressures the program counter while a fetch is in flight, and supports flush on taken branch/jump.

---
 rtl/mips8_pkg.sv | 17 +
 rtl/fetch_byte_assembler.sv | 32 +++
 rtl/instruction_fetch.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mips8_pkg.sv
// Shared constants and types for the 8-bit MIPS fetch path.
package mips8_pkg;

  localparam int unsigned ADDR_WIDTH      = 8;
  localparam int unsigned INSTR_WIDTH     = 32;
  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam int unsigned BYTE_WIDTH      = 8;
  localparam int unsigned K_WIDTH         = $clog2(BYTES_PER_INSTR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_byte_assembler.sv
// Shifts returned memory bytes into a shadow word (big-endian) and loads the
// visible instruction register only on commit.
module fetch_byte_assembler
  import mips8_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  shift_en,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  input  logic                  commit,
  output logic [WORD_WIDTH-1:0] instr
);

  logic [WORD_WIDTH-1:0] shadow;
  logic [WORD_WIDTH-1:0] shadow_nxt;

  // First byte shifted in ends up in the most significant position.
  assign shadow_nxt = {shadow[WORD_WIDTH-BYTE_WIDTH-1:0], byte_in};

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow <= '0;
      instr  <= '0;
    end else begin
      if (shift_en) shadow <= shadow_nxt;
      if (commit)   instr  <= shadow_nxt;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch responder: reads four bytes per instruction from byte-wide memory,
// assembles them big-endian and hands the word to the decoder.
module instruction_fetch #(
  parameter int unsigned ADDR_WIDTH  = mips8_pkg::ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = mips8_pkg::INSTR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  pc_address,
  input  logic                   pc_valid,
  output logic                   pc_ready,
  input  logic                   flush,
  output logic                   mem_rd,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [7:0]             mem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic                   misaligned
);

  import mips8_pkg::fetch_state_t;
  import mips8_pkg::IDLE;
  import mips8_pkg::ISSUE;
  import mips8_pkg::DRAIN;
  import mips8_pkg::DONE;
  import mips8_pkg::K_WIDTH;
  import mips8_pkg::BYTES_PER_INSTR;

  localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(BYTES_PER_INSTR - 1);

  fetch_state_t          state, state_nxt;
  logic [K_WIDTH-1:0]    k, k_nxt;
  logic [ADDR_WIDTH-1:0] base, base_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic                  mem_rd_nxt, pc_ready_nxt, instr_valid_nxt, misaligned_nxt;
  logic                  accept, aligned, commit;
  logic                  rd_d1;

  assign accept  = pc_valid & pc_ready & ~flush;
  assign aligned = (pc_address[1:0] == 2'b00);

  // Next-state and next-output decode.
  always_comb begin
    state_nxt      = state;
    k_nxt          = k;
    base_nxt       = base;
    misaligned_nxt = 1'b0;
    commit         = 1'b0;

    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept) begin
          base_nxt = pc_address;
          if (aligned) begin
            state_nxt = ISSUE;
            k_nxt     = '0;
          end else begin
            misaligned_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        k_nxt = K_WIDTH'(k + K_WIDTH'(1));
        if (k == K_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = DONE;
        commit    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort wins over everything except reset.
    if (flush) begin
      state_nxt = IDLE;
      commit    = 1'b0;
    end

    mem_rd_nxt      = (state_nxt == ISSUE);
    mem_addr_nxt    = mem_rd_nxt ? ADDR_WIDTH'(base_nxt + ADDR_WIDTH'(k_nxt)) : mem_addr;
    pc_ready_nxt    = (state_nxt == IDLE) || (state_nxt == DONE);
    instr_valid_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      k           <= '0;
      base        <= '0;
      pc_ready    <= 1'b1;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
      rd_d1       <= 1'b0;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      base        <= base_nxt;
      pc_ready    <= pc_ready_nxt;
      mem_rd      <= mem_rd_nxt;
      mem_addr    <= mem_addr_nxt;
      instr_valid <= instr_valid_nxt;
      misaligned  <= misaligned_nxt;
      rd_d1       <= mem_rd;
    end
  end

  // Read data lags the strobe by one cycle, so capture follows rd_d1.
  fetch_byte_assembler #(
    .WORD_WIDTH(INSTR_WIDTH)
  ) u_asm (
    .clock    (clock),
    .reset    (reset),
    .shift_en (rd_d1),
    .byte_in  (mem_rdata),
    .commit   (commit),
    .instr    (instr)
  );

endmodule
